// File: rtl/dpc_bp_table_merger.sv
// Collects auto-detected bad pixels per frame, then merges them with the host
// manual table (both ascending {y,x}) into the corrector's all-BP table.
module dpc_bp_table_merger #(
  parameter int MANUAL_BP_NUM = 128,
  parameter int MANUAL_BP_BIT = 7,
  parameter int AUTO_BP_NUM   = 256,
  parameter int AUTO_BP_BIT   = 8,
  parameter int ALL_BP_BIT    = 9,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     axis_aclk,
  input  logic                     axis_aresetn,
  input  logic                     enable,
  input  logic                     auto_bp_valid,
  input  logic [9:0]               auto_bp_x,
  input  logic [9:0]               auto_bp_y,
  input  logic                     auto_bp_type,
  output logic                     auto_bp_ready,
  input  logic                     frame_detection_done,
  input  logic [MANUAL_BP_BIT-1:0] manual_bp_num,
  output logic [MANUAL_BP_BIT-1:0] manual_raddr,
  input  logic [DATA_WIDTH-1:0]    manual_rdata,
  output logic                     all_wen,
  output logic [ALL_BP_BIT-1:0]    all_waddr,
  output logic [DATA_WIDTH-1:0]    all_wdata,
  output logic [ALL_BP_BIT-1:0]    all_bp_num,
  output logic                     bp_table_ready,
  output logic                     merge_busy,
  output logic                     auto_drop,
  output logic                     table_overflow,
  output logic [8:0]               dup_count,
  output logic [2:0]               o_dbg_state
);

  // Handshake: an auto entry transfers on a cycle where auto_bp_valid and
  // auto_bp_ready are both high at the rising edge; ready is held high for the
  // whole of COLLECT, so entries beyond buffer capacity are accepted and dropped.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_LOAD    = 3'd2,
    S_FETCH   = 3'd3,
    S_MERGE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [AUTO_BP_BIT:0]   AUTO_FULL = (AUTO_BP_BIT+1)'(AUTO_BP_NUM);
  localparam logic [ALL_BP_BIT-1:0]  CAP       = '1;

  state_t                   r_state, w_state_n;
  logic [AUTO_BP_BIT:0]     r_acnt;
  logic [AUTO_BP_BIT:0]     r_ai, w_ai_n;
  logic [MANUAL_BP_BIT-1:0] r_mi, w_mi_n;
  logic [ALL_BP_BIT-1:0]    r_wi;
  logic [ALL_BP_BIT-1:0]    r_bp_num;
  logic                     r_ready;
  logic                     r_drop;
  logic                     r_ovf;
  logic [8:0]               r_dup;
  logic [20:0]              r_auto_mem [AUTO_BP_NUM];
  logic [20:0]              r_auto_rd;

  logic                     w_wen;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic                     w_store;
  logic                     w_drop_set;
  logic                     w_ovf_set;
  logic                     w_dup_inc;
  logic                     w_m_ex;
  logic                     w_a_ex;
  logic [19:0]              w_m_key;
  logic [19:0]              w_a_key;
  logic [AUTO_BP_BIT-1:0]   w_arad;
  logic                     w_unused_rdata;

  assign w_m_ex  = (r_mi == manual_bp_num);
  assign w_a_ex  = (r_ai == r_acnt);
  assign w_m_key = manual_rdata[19:0];
  assign w_a_key = r_auto_rd[19:0];
  assign w_arad  = (r_state == S_LOAD) ? '0 : r_ai[AUTO_BP_BIT-1:0];
  assign w_unused_rdata = &{1'b0, manual_rdata[DATA_WIDTH-1:20]};

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) r_state <= S_IDLE;
    else               r_state <= w_state_n;
  end

  always_comb begin
    w_state_n  = r_state;
    w_wen      = 1'b0;
    w_wdata    = '0;
    w_mi_n     = r_mi;
    w_ai_n     = r_ai;
    w_store    = 1'b0;
    w_drop_set = 1'b0;
    w_ovf_set  = 1'b0;
    w_dup_inc  = 1'b0;
    case (r_state)
      S_IDLE: if (enable) w_state_n = S_COLLECT;
      S_COLLECT: begin
        if (auto_bp_valid) begin
          if (r_acnt == AUTO_FULL) w_drop_set = 1'b1;
          else                     w_store    = 1'b1;
        end
        if (frame_detection_done) w_state_n = S_LOAD;
        else if (!enable)         w_state_n = S_IDLE;
      end
      S_LOAD: begin
        if (manual_bp_num == '0 && r_acnt == '0) w_state_n = S_DONE;
        else                                     w_state_n = S_FETCH;
      end
      S_FETCH: w_state_n = S_MERGE;
      S_MERGE: begin
        if (w_m_ex && w_a_ex) begin
          w_state_n = S_DONE;
        end else if (r_wi == CAP) begin
          w_ovf_set = 1'b1;
          w_state_n = S_DONE;
        end else begin
          w_wen = 1'b1;
          if (w_m_ex || (!w_a_ex && (w_a_key < w_m_key))) begin
            w_wdata[22:0] = {2'b10, r_auto_rd[20], w_a_key};
            w_ai_n        = r_ai + 1'b1;
          end else if (w_a_ex || (w_m_key < w_a_key)) begin
            w_wdata[22:0] = {2'b01, 1'b0, w_m_key};
            w_mi_n        = r_mi + 1'b1;
          end else begin
            w_wdata[22:0] = {2'b11, r_auto_rd[20], w_a_key};
            w_ai_n        = r_ai + 1'b1;
            w_mi_n        = r_mi + 1'b1;
            w_dup_inc     = 1'b1;
          end
          // Look ahead so the last write goes straight to DONE.
          if (w_mi_n == manual_bp_num && w_ai_n == r_acnt) w_state_n = S_DONE;
          else                                             w_state_n = S_FETCH;
        end
      end
      S_DONE: w_state_n = enable ? S_COLLECT : S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_acnt   <= '0;
      r_ai     <= '0;
      r_mi     <= '0;
      r_wi     <= '0;
      r_bp_num <= '0;
      r_ready  <= 1'b0;
      r_drop   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dup    <= '0;
    end else begin
      if (w_store)    r_acnt <= r_acnt + 1'b1;
      if (w_drop_set) r_drop <= 1'b1;
      if (w_ovf_set)  r_ovf  <= 1'b1;
      if (w_state_n == S_COLLECT && r_state != S_COLLECT) begin
        r_drop <= 1'b0;
        r_ovf  <= 1'b0;
      end
      case (r_state)
        S_COLLECT: if (w_state_n == S_IDLE) r_acnt <= '0;
        S_LOAD: begin
          r_mi    <= '0;
          r_ai    <= '0;
          r_wi    <= '0;
          r_dup   <= '0;
          r_ready <= 1'b0;
        end
        S_MERGE: begin
          r_mi <= w_mi_n;
          r_ai <= w_ai_n;
          if (w_wen)     r_wi  <= r_wi + 1'b1;
          if (w_dup_inc) r_dup <= r_dup + 9'd1;
        end
        S_DONE: begin
          r_bp_num <= r_wi;
          r_ready  <= 1'b1;
          r_acnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Buffer contents need no reset: r_acnt defines which entries are live.
  always_ff @(posedge axis_aclk) begin
    if (w_store) r_auto_mem[r_acnt[AUTO_BP_BIT-1:0]] <= {auto_bp_type, auto_bp_y, auto_bp_x};
    r_auto_rd <= r_auto_mem[w_arad];
  end

  assign auto_bp_ready  = (r_state == S_COLLECT);
  assign manual_raddr   = (r_state == S_LOAD) ? '0 : r_mi;
  assign all_wen        = w_wen;
  assign all_waddr      = r_wi;
  assign all_wdata      = w_wdata;
  assign all_bp_num     = r_bp_num;
  assign bp_table_ready = r_ready;
  assign merge_busy     = (r_state == S_LOAD) || (r_state == S_FETCH) ||
                          (r_state == S_MERGE) || (r_state == S_DONE);
  assign auto_drop      = r_drop;
  assign table_overflow = r_ovf;
  assign dup_count      = r_dup;
  assign o_dbg_state    = r_state;

endmodule
